// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that steps two NIBBLES*4-bit operands LSB-first through one shared
// external 4-bit adder, chaining carry in a register, and returns the result via valid/ready.
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [4*NIBBLES-1:0]   op_a_i,
    input  logic [4*NIBBLES-1:0]   op_b_i,
    input  logic                   op_sub_i,
    input  logic                   op_cin_i,
    output logic [3:0]             add_a_o,
    output logic [3:0]             add_b_o,
    output logic                   add_cin_o,
    input  logic [3:0]             add_sum_i,
    input  logic                   add_cout_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [4*NIBBLES-1:0]   result_o,
    output logic                   carry_out_o,
    output logic                   overflow_o
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [NIBBLES-1:0][3:0] a_q, b_q, res_q;
    logic [IW-1:0]           idx_q;
    logic                    carry_q, cout_q, ovf_q;
    logic                    last_nib;

    assign last_nib = (idx_q == IW'(NIBBLES - 1));

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        add_a_o     = 4'h0;
        add_b_o     = 4'h0;
        add_cin_o   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = RUN;
            end
            RUN: begin
                add_a_o   = a_q[idx_q];
                add_b_o   = b_q[idx_q];
                add_cin_o = carry_q;
                if (last_nib) state_d = DONE;
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // B is stored pre-inverted for subtract, so the signed-overflow test below
    // compares against the operand the adder actually saw.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= op_a_i;
                        b_q     <= op_sub_i ? ~op_b_i : op_b_i;
                        carry_q <= op_sub_i | op_cin_i;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    res_q[idx_q] <= add_sum_i;
                    carry_q      <= add_cout_i;
                    idx_q        <= idx_q + 1'b1;
                    if (last_nib) begin
                        cout_q <= add_cout_i;
                        ovf_q  <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                                  (add_sum_i[3] != a_q[NIBBLES-1][3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o    = res_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;

endmodule
